// File: rtl/uart_bridge_pkg.sv
// Shared types and constants for the UART bridge transmit path.
package uart_bridge_pkg;

   localparam int FRAME_BITS     = 11;
   localparam int DEFAULT_DATA_W = 8;
   localparam int DEFAULT_CNT_W  = 3;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_e;

endpackage

// File: rtl/uart_tx_byte_cnt.sv
// Per-packet byte counter: active-low clear has priority over increment, wraps at 2^CNT_W.
module uart_tx_byte_cnt
   import uart_bridge_pkg::*;
#(
   parameter int CNT_W = DEFAULT_CNT_W
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             clr_n_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] count_o
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (!clr_n_i) begin
         count_d = '0;
      end else if (inc_i) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start / DATA_W bits LSB-first / parity / stop, advanced on tx_en ticks.
module uart_tx_frame
   import uart_bridge_pkg::*;
#(
   parameter int DATA_W     = DEFAULT_DATA_W,
   parameter int PARITY_ODD = 0,
   parameter int CNT_W      = DEFAULT_CNT_W
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              tx_en,
   input  logic [DATA_W-1:0] OutData,
   input  logic              DataVLD_farme,
   input  logic              ENBI,
   input  logic              ENBY,
   input  logic              BYCRST,
   input  logic              Err,
   output logic              TX,
   output logic              Bit_done,
   output logic [CNT_W-1:0]  count,
   output logic              FBUSY
);

   localparam int   IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic PAR_BASE = (PARITY_ODD != 0);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

   tx_state_e         state_q;
   logic [DATA_W-1:0] shreg_q;
   logic [IDX_W-1:0]  idx_q;
   logic [IDX_W-1:0]  idx_d;
   logic              par_q;
   logic              par_d;
   logic              tx_q;
   logic              done_q;
   logic              busy_q;
   logic              cnt_inc;

   assign idx_d = idx_q + IDX_W'(1);
   assign par_d = (^OutData) ^ PAR_BASE ^ Err;

   // state_q names the bit currently driven on TX; Bit_done drops on the very next CLK
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q <= IDLE;
         shreg_q <= '0;
         idx_q   <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (tx_en) begin
            case (state_q)
               IDLE: begin
                  if (DataVLD_farme && ENBI) begin
                     shreg_q <= OutData;
                     par_q   <= par_d;
                     tx_q    <= 1'b0;
                     state_q <= START;
                     busy_q  <= 1'b1;
                  end
               end
               START: begin
                  tx_q    <= shreg_q[0];
                  idx_q   <= '0;
                  state_q <= DATA;
               end
               DATA: begin
                  if (idx_q != IDX_LAST) begin
                     idx_q <= idx_d;
                     tx_q  <= shreg_q[idx_d];
                  end else begin
                     tx_q    <= par_q;
                     state_q <= PARITY;
                  end
               end
               PARITY: begin
                  tx_q    <= 1'b1;
                  state_q <= STOP;
               end
               STOP: begin
                  done_q  <= 1'b1;
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
               default: begin
                  tx_q    <= 1'b1;
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign cnt_inc = tx_en & (state_q == STOP) & ENBY;

   uart_tx_byte_cnt #(
      .CNT_W(CNT_W)
   ) u_byte_cnt (
      .CLK     (CLK),
      .RST     (RST),
      .clr_n_i (BYCRST),
      .inc_i   (cnt_inc),
      .count_o (count)
   );

   assign TX       = tx_q;
   assign Bit_done = done_q;
   assign FBUSY    = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench: per-cycle comparison against a frame-position reference model, plus directed scenarios.
module tb_uart_tx_frame;

   localparam int DATA_W     = 8;
   localparam int PARITY_ODD = 0;
   localparam int CNT_W      = 3;

   logic              CLK = 1'b0;
   logic              RST;
   logic              tx_en;
   logic [DATA_W-1:0] OutData;
   logic              DataVLD_farme;
   logic              ENBI;
   logic              ENBY;
   logic              BYCRST;
   logic              Err;
   logic              TX;
   logic              Bit_done;
   logic [CNT_W-1:0]  count;
   logic              FBUSY;

   always #5 CLK = ~CLK;

   uart_tx_frame #(
      .DATA_W     (DATA_W),
      .PARITY_ODD (PARITY_ODD),
      .CNT_W      (CNT_W)
   ) dut (
      .CLK           (CLK),
      .RST           (RST),
      .tx_en         (tx_en),
      .OutData       (OutData),
      .DataVLD_farme (DataVLD_farme),
      .ENBI          (ENBI),
      .ENBY          (ENBY),
      .BYCRST        (BYCRST),
      .Err           (Err),
      .TX            (TX),
      .Bit_done      (Bit_done),
      .count         (count),
      .FBUSY         (FBUSY)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model: position within an 11-bit frame (-1 = idle line)
   int   m_pos   = -1;
   logic m_frame [0:10];
   int   m_cnt   = 0;
   logic m_done  = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_step();
      if (!RST) begin
         m_pos  = -1;
         m_cnt  = 0;
         m_done = 1'b0;
      end else begin
         m_done = 1'b0;
         if (tx_en) begin
            if (m_pos < 0) begin
               if (DataVLD_farme && ENBI) begin
                  m_frame[0] = 1'b0;
                  for (int i = 0; i < DATA_W; i++) m_frame[1+i] = OutData[i];
                  m_frame[9]  = 1'(($countones(OutData) + PARITY_ODD + int'(Err)) % 2);
                  m_frame[10] = 1'b1;
                  m_pos = 0;
               end
            end else if (m_pos == 10) begin
               m_done = 1'b1;
               m_pos  = -1;
               if (ENBY && BYCRST) m_cnt = (m_cnt + 1) % (1 << CNT_W);
            end else begin
               m_pos++;
            end
         end
         if (!BYCRST) m_cnt = 0;
      end
   endtask

   // One CLK: update model at the edge, compare all outputs 1 time unit later
   task automatic step();
      logic m_tx;
      @(posedge CLK);
      model_step();
      #1;
      m_tx = (m_pos < 0) ? 1'b1 : m_frame[m_pos];
      check_eq("tx",    32'(TX),       32'(m_tx));
      check_eq("fbusy", 32'(FBUSY),    32'(m_pos >= 0));
      check_eq("done",  32'(Bit_done), 32'(m_done));
      check_eq("count", 32'(count),    32'(m_cnt));
   endtask

   task automatic baud(input int gap);
      tx_en = 1'b0;
      repeat (gap) step();
      tx_en = 1'b1;
      step();
      tx_en = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic e,
                             output logic [10:0] bits, output int busy_n, output int done_n);
      bits          = '0;
      busy_n        = 0;
      done_n        = 0;
      OutData       = b;
      Err           = e;
      DataVLD_farme = 1'b1;
      for (int k = 0; k < 12; k++) begin
         baud($urandom_range(0, 2));
         if (k == 0) begin
            DataVLD_farme = 1'b0;
            OutData       = 8'($urandom);
            Err           = ~e;
         end
         if (k < 11) bits[k] = TX;
         busy_n += int'(FBUSY);
         done_n += int'(Bit_done);
      end
      Err = 1'b0;
   endtask

   initial begin
      logic [10:0] bits;
      int          busy_n;
      int          done_n;
      int          frames;
      int          ticks;
      int          done_tick;
      int          exp_a5 [0:10];
      logic [7:0]  b;

      exp_a5 = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};

      RST = 1'b0; tx_en = 1'b0; OutData = '0; DataVLD_farme = 1'b0;
      ENBI = 1'b1; ENBY = 1'b1; BYCRST = 1'b1; Err = 1'b0;
      repeat (3) step();
      check_eq("reset_tx", 32'(TX), 32'd1);
      check_eq("reset_busy", 32'(FBUSY), 32'd0);
      check_eq("reset_count", 32'(count), 32'd0);
      RST = 1'b1;

      // Idle line with no valid data
      done_n = 0;
      busy_n = 0;
      for (int k = 0; k < 20; k++) begin
         baud(1);
         done_n += int'(Bit_done);
         busy_n += int'(FBUSY) + int'(!TX);
      end
      check_eq("idle_done_pulses", 32'(done_n), 32'd0);
      check_eq("idle_busy_or_low", 32'(busy_n), 32'd0);

      // 8'hA5, even parity
      send_frame(8'hA5, 1'b0, bits, busy_n, done_n);
      for (int k = 0; k < 11; k++) check_eq($sformatf("a5_bit%0d", k), 32'(bits[k]), 32'(exp_a5[k]));
      check_eq("a5_busy_ticks", 32'(busy_n), 32'd11);
      check_eq("a5_done_pulses", 32'(done_n), 32'd1);
      check_eq("a5_count", 32'(count), 32'd1);

      // Same byte with Err: only the parity bit flips
      exp_a5[9] = 1;
      send_frame(8'hA5, 1'b1, bits, busy_n, done_n);
      for (int k = 0; k < 11; k++) check_eq($sformatf("a5err_bit%0d", k), 32'(bits[k]), 32'(exp_a5[k]));
      check_eq("a5err_count", 32'(count), 32'd2);

      // Clear count without any tick
      BYCRST = 1'b0;
      step();
      check_eq("clr_no_tick", 32'(count), 32'd0);
      BYCRST = 1'b1;

      // Back-to-back frames with valid held; byte advances on each completed frame
      frames        = 0;
      ticks         = 0;
      done_tick     = 0;
      b             = 8'h01;
      OutData       = b;
      DataVLD_farme = 1'b1;
      while (frames < 8 && ticks < 120) begin
         baud(1);
         ticks++;
         if (Bit_done) begin
            frames++;
            done_tick = ticks;
            check_eq($sformatf("b2b_count_f%0d", frames), 32'(count), 32'(frames % 8));
            b++;
            OutData = b;
         end
      end
      DataVLD_farme = 1'b0;
      check_eq("b2b_frames", 32'(frames), 32'd8);
      check_eq("b2b_pitch_ticks", 32'(done_tick), 32'd96);
      check_eq("b2b_wrap_count", 32'(count), 32'd0);
      baud(0);

      // Clear coinciding with the STOP tick at count=3
      for (int f = 0; f < 3; f++) send_frame(8'($urandom), 1'($urandom), bits, busy_n, done_n);
      check_eq("pre_clr_count", 32'(count), 32'd3);
      OutData       = 8'h3C;
      DataVLD_farme = 1'b1;
      baud(1);
      DataVLD_farme = 1'b0;
      for (int k = 0; k < 10; k++) baud(1);
      BYCRST = 1'b0;
      baud(1);
      check_eq("stop_clr_count", 32'(count), 32'd0);
      check_eq("stop_clr_done", 32'(Bit_done), 32'd1);
      repeat (5) step();
      check_eq("clr_hold_count", 32'(count), 32'd0);
      BYCRST = 1'b1;

      // Reset during data bit 4 of 8'hFF
      send_frame(8'h55, 1'b0, bits, busy_n, done_n);
      OutData       = 8'hFF;
      DataVLD_farme = 1'b1;
      baud(1);
      DataVLD_farme = 1'b0;
      for (int k = 0; k < 5; k++) baud(1);
      check_eq("pre_rst_busy", 32'(FBUSY), 32'd1);
      RST = 1'b0;
      step();
      check_eq("rst_tx", 32'(TX), 32'd1);
      check_eq("rst_busy", 32'(FBUSY), 32'd0);
      check_eq("rst_count", 32'(count), 32'd0);
      RST    = 1'b1;
      busy_n = 0;
      for (int k = 0; k < 15; k++) begin
         baud(1);
         busy_n += int'(FBUSY) + int'(Bit_done);
      end
      check_eq("post_rst_quiet", 32'(busy_n), 32'd0);

      // Randomised traffic against the model
      for (int k = 0; k < 400; k++) begin
         DataVLD_farme = ($urandom_range(0, 1) == 1);
         ENBI          = ($urandom_range(0, 9) < 8);
         ENBY          = ($urandom_range(0, 9) < 8);
         BYCRST        = ($urandom_range(0, 19) != 0);
         Err           = ($urandom_range(0, 4) == 0);
         OutData       = 8'($urandom);
         RST           = ($urandom_range(0, 99) != 0);
         baud($urandom_range(0, 3));
      end
      RST = 1'b1;
      baud(1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- Serial UART transmitter stage, directly downstream of the bridge's outbound data FSM.
- Takes one byte at a time (OutData plus framing enables) and serialises it as start / 8 data LSB-first / parity / stop, paced by the tx_en baud tick.
- Returns the per-frame byte counter (count), a frame-done pulse (Bit_done) and the busy flag (FBUSY) that the data FSM sequences on.

Parameters:
DATA_W, 8, data bits per frame
PARITY_ODD, 0, 0 = even parity, 1 = odd parity
CNT_W, 3, byte-counter width

Ports:
CLK  in  1  system clock
RST  in  1  reset; synchronous, active-low (sampled on CLK rising edge)
tx_en  in  1  baud tick, one CLK wide, one per bit period
OutData  in  DATA_W  byte to transmit
DataVLD_farme  in  1  byte on OutData is valid for framing
ENBI  in  1  bit-engine enable; qualifies frame start
ENBY  in  1  byte-counter increment enable
BYCRST  in  1  byte-counter clear, active-low
Err  in  1  corrupt this frame's parity
TX  out  1  serial line, idle high
Bit_done  out  1  one-CLK pulse at end of each stop bit
count  out  CNT_W  bytes completed in current packet
FBUSY  out  1  frame in progress

Behaviour:
- Reset (RST=0 at a CLK edge): state=IDLE, TX=1, count=0, Bit_done=0, FBUSY=0, shift register and bit index cleared. Applies mid-frame: the frame is aborted and the line returns high on that edge.
- All state and TX updates happen only on CLK edges with tx_en=1. Exceptions: the count clear and the Bit_done de-assert, described below.
- TX is registered; the state names the bit currently on the line.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: TX=1.
  - On a tick with DataVLD_farme & ENBI: latch OutData into the shift register; latch par = (^OutData) ^ PARITY_ODD ^ Err; TX<=0; go to START.
  - Otherwise stay in IDLE.
- START: on a tick, TX<=d[0], bit index=0, go to DATA.
- DATA: on a tick with index<DATA_W-1, index++ and TX<=d[index+1]. At index=DATA_W-1, TX<=par and go to PARITY.
- PARITY: on a tick, TX<=1, go to STOP.
- STOP: on a tick:
  - Bit_done=1 for exactly that CLK cycle.
  - If ENBY & BYCRST, count<=count+1, wrapping from 2^CNT_W-1 to 0.
  - Go to IDLE.
- Inter-frame gap: a new frame can start at the tick after STOP, so every byte is followed by at least one extra idle-high bit period (frame pitch is 12 ticks minimum).
- Data and parity are latched only at start. Changes to OutData, Err or DataVLD_farme mid-frame have no effect, and ENBI falling mid-frame does not abort the frame.
- BYCRST=0 clears count to 0 on every CLK edge, independent of tx_en, and takes priority over increment. If the clear coincides with the STOP tick, count=0 and Bit_done still pulses.
- FBUSY = (state != IDLE), registered with the state.
- Handshake consequence: count changes on the same edge that ends STOP. On the next tick, the upstream FSM either presents the next byte or leaves its state. Either way, the byte visible on that tick is the one latched.
- Err=1 at start inverts the parity bit only; data bits are unaffected.

Decomposition:
- Shared package uart_bridge_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP, 3-bit encoding);
  - the FRAME_BITS=11 constant;
  - the default DATA_W and CNT_W values.
- One natural sub-module, uart_tx_byte_cnt: the CNT_W counter with active-low clear, increment enable and wrap. Parity is a single XOR-reduce inline, not a module.

Test Plan:
- Reset, then tick 20 times with DataVLD_farme=0 -> TX=1 throughout, FBUSY=0, count=0, no Bit_done.
- OutData=8'hA5, ENBI=ENBY=BYCRST=1, Err=0, even parity, valid held one tick -> TX per tick 0,1,0,1,0,0,1,0,1,0(par),1 (stop). Bit_done pulses once. count 0->1. FBUSY high for 11 ticks.
- Same byte with Err=1 -> parity bit =1; all other bits identical.
- Back-to-back: valid held high with bytes 8'h01..8'h07 advanced on each count change -> 7 frames, each separated by exactly one idle tick. count runs 1..7, then wraps to 0 on an 8th frame.
- BYCRST=0 asserted on the STOP tick with count=3 -> count=0, Bit_done still pulses; hold BYCRST=0 without tx_en -> count stays 0.
- RST=0 during DATA bit 4 of 8'hFF -> next CLK edge: TX=1, FBUSY=0, count=0. After release, no residual frame resumes.
